// File: rtl/apb_slave_pkg.sv
// Shared types for the APB register-file slave: FSM states, error codes, byte-lane merge helper.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO
  } apb_err_e;

  // One byte lane of a strobed write; callers iterate over lanes so any DATA_W works.
  function automatic logic [7:0] strb_merge(input logic [7:0] old,
                                            input logic [7:0] wdata,
                                            input logic       strb);
    return strb ? wdata : old;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage with a single byte-strobed write port; write lands on the clock edge it is valid.
// RO registers have no flops and read back as zero; no backpressure.
module apb_reg_bank
  import apb_slave_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 16,
  parameter int                  IDX_W    = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_vld,
  input  logic [IDX_W-1:0]             i_wr_idx,
  input  logic [DATA_W-1:0]            i_wr_dat,
  input  logic [DATA_W/8-1:0]          i_wr_strb,
  output logic [NUM_REGS*DATA_W-1:0]   o_reg_q
);

  localparam int NB = DATA_W / 8;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign o_reg_q[i*DATA_W +: DATA_W] = '0;
    end else begin : g_rw
      logic [DATA_W-1:0] r_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_q <= '0;
        end else if (i_wr_vld && (i_wr_idx == IDX_W'(i))) begin
          for (int b = 0; b < NB; b++) begin
            r_q[b*8 +: 8] <= strb_merge(r_q[b*8 +: 8], i_wr_dat[b*8 +: 8], i_wr_strb[b]);
          end
        end
      end

      assign o_reg_q[i*DATA_W +: DATA_W] = r_q;
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB4 register-file slave: PREADY in cycle T1+WAIT_CYCLES after setup, write commits on the completing edge.
// Dropping PSEL during wait states aborts the transfer silently; RESP always completes in one cycle.
module apb_reg_slave
  import apb_slave_pkg::*;
#(
  parameter int                  DATA_W      = 32,
  parameter int                  ADDR_W      = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/8-1:0]          PSTRB,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_val,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'(NB - 1);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);
  localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  apb_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                w_capture;

  logic [IDX_W-1:0]    r_idx;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdat;
  logic [NB-1:0]       r_strb;
  apb_err_e            r_err_code;

  logic [ADDR_W-1:0]   w_word;
  logic [IDX_W-1:0]    w_idx;
  apb_err_e            w_err_code;

  logic                w_from_idle;
  logic [IDX_W-1:0]    w_rsp_idx;
  logic                w_rsp_write;
  logic                w_rsp_err;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_commit;

  logic [DATA_W-1:0]   r_prdata;
  logic                r_pready;
  logic                r_pslverr;
  logic [NUM_REGS-1:0] r_wr_pulse;

  assign w_word = PADDR >> OFF_W;
  assign w_idx  = w_word[IDX_W-1:0];

  always_comb begin
    w_err_code = ERR_NONE;
    if ((PADDR & OFF_MASK) != '0) begin
      w_err_code = ERR_ALIGN;
    end else if (w_word >= NUM_REGS_A) begin
      w_err_code = ERR_RANGE;
    end else if (PWRITE && RO_MASK[w_idx]) begin
      w_err_code = ERR_RO;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end else begin
            w_state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_wdat     <= '0;
      r_strb     <= '0;
      r_err_code <= ERR_NONE;
    end else if (w_capture) begin
      r_idx      <= w_idx;
      r_write    <= PWRITE;
      r_wdat     <= PWDATA;
      r_strb     <= PSTRB;
      r_err_code <= w_err_code;
    end
  end

  // Zero-wait transfers enter RESP on the setup edge itself, before the capture registers hold anything.
  assign w_from_idle = (r_state == IDLE);
  assign w_rsp_idx   = w_from_idle ? w_idx : r_idx;
  assign w_rsp_write = w_from_idle ? PWRITE : r_write;
  assign w_rsp_err   = w_from_idle ? (w_err_code != ERR_NONE) : (r_err_code != ERR_NONE);
  assign w_rd_word   = RO_MASK[w_rsp_idx] ? ro_val[w_rsp_idx*DATA_W +: DATA_W]
                                          : reg_q[w_rsp_idx*DATA_W +: DATA_W];

  assign w_commit = (r_state == RESP) && r_write && (r_err_code == ERR_NONE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_pready   <= (w_state_nxt == RESP);
      r_pslverr  <= (w_state_nxt == RESP) && w_rsp_err;
      r_prdata   <= ((w_state_nxt == RESP) && !w_rsp_write && !w_rsp_err) ? w_rd_word : '0;
      r_wr_pulse <= w_commit ? (NUM_REGS'(1) << r_idx) : '0;
    end
  end

  apb_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .RO_MASK  (RO_MASK)
  ) u_bank (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_wr_vld  (w_commit),
    .i_wr_idx  (r_idx),
    .i_wr_dat  (r_wdat),
    .i_wr_strb (r_strb),
    .o_reg_q   (reg_q)
  );

  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign PSLVERR  = r_pslverr;
  assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Two slaves (zero-wait and three-wait) driven from one APB master and checked every cycle against a register model.
module tb_apb_reg_slave;

  localparam int          ND   = 2;
  localparam int          NR   = 16;
  localparam logic [15:0] RO_A = 16'h0008;
  localparam logic [15:0] RO_B = 16'h0208;

  int          waits [ND] = '{0, 3};
  logic [15:0] ro_m  [ND];
  logic [31:0] rv    [ND][NR];

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic          penable, pwrite;
  logic [31:0]   paddr, pwdata;
  logic [3:0]    pstrb;
  logic          psel     [ND];
  logic          presetn  [ND];
  logic [31:0]   prdata   [ND];
  logic          pready   [ND];
  logic          pslverr  [ND];
  logic [NR*32-1:0] reg_q [ND];
  logic [NR*32-1:0] ro_val[ND];
  logic [NR-1:0] wr_pulse [ND];

  apb_reg_slave #(.WAIT_CYCLES(0), .RO_MASK(RO_A)) u_dut_a (
    .PCLK(PCLK), .PRESETn(presetn[0]), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .reg_q(reg_q[0]), .ro_val(ro_val[0]), .wr_pulse(wr_pulse[0]));

  apb_reg_slave #(.WAIT_CYCLES(3), .RO_MASK(RO_B)) u_dut_b (
    .PCLK(PCLK), .PRESETn(presetn[1]), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .reg_q(reg_q[1]), .ro_val(ro_val[1]), .wr_pulse(wr_pulse[1]));

  // Model: register contents plus what each slave must show in the current cycle.
  logic [31:0] mreg        [ND][NR];
  logic        exp_pready  [ND];
  logic        exp_pslverr [ND];
  logic [31:0] exp_prdata  [ND];
  logic [NR-1:0] exp_wp    [ND];
  logic        pend_wr     [ND];
  int          pend_idx    [ND];
  logic [31:0] pend_dat    [ND];
  logic [3:0]  pend_strb   [ND];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input int d, input int i,
                              input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d[%0d]: got %h, expected %h at %0t", name, d, i, act, exp, $time);
    end
  endfunction

  always @(negedge PCLK) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        chk("pready",   d, 0, {31'b0, pready[d]},  {31'b0, exp_pready[d]});
        chk("pslverr",  d, 0, {31'b0, pslverr[d]}, {31'b0, exp_pslverr[d]});
        chk("prdata",   d, 0, prdata[d], exp_prdata[d]);
        chk("wr_pulse", d, 0, {16'b0, wr_pulse[d]}, {16'b0, exp_wp[d]});
        for (int i = 0; i < NR; i++) begin
          chk("reg_q", d, i, reg_q[d][i*32 +: 32], mreg[d][i]);
        end
      end
    end
  end

  function automatic bit m_err(input int d, input logic [31:0] addr, input logic wr);
    int unsigned idx;
    idx = addr >> 2;
    if (addr[1:0] != 2'b00) return 1'b1;
    if (idx >= NR) return 1'b1;
    if (wr && ro_m[d][idx]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] addr);
    int unsigned idx;
    idx = addr >> 2;
    return ro_m[d][idx] ? rv[d][idx] : mreg[d][idx];
  endfunction

  task automatic model_reset(input int d);
    for (int i = 0; i < NR; i++) mreg[d][i] = '0;
    exp_pready[d]  = 1'b0;
    exp_pslverr[d] = 1'b0;
    exp_prdata[d]  = '0;
    exp_wp[d]      = '0;
    pend_wr[d]     = 1'b0;
  endtask

  // Advance one cycle; a write completed last cycle becomes visible now.
  task automatic step();
    @(posedge PCLK);
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_pready[d]  = 1'b0;
      exp_pslverr[d] = 1'b0;
      exp_prdata[d]  = '0;
      exp_wp[d]      = '0;
      if (pend_wr[d]) begin
        for (int b = 0; b < 4; b++) begin
          if (pend_strb[d][b]) mreg[d][pend_idx[d]][b*8 +: 8] = pend_dat[d][b*8 +: 8];
        end
        exp_wp[d][pend_idx[d]] = 1'b1;
        pend_wr[d] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    int s;
    for (int k = 0; k < n; k++) begin
      step();
      for (int d = 0; d < ND; d++) psel[d] = 1'b0;
      penable = 1'b0;
      if ($urandom_range(3) == 0) begin
        s = $urandom_range(ND - 1);
        psel[s] = 1'b1;
        penable = 1'b1;
      end
      @(negedge PCLK);
    end
  endtask

  task automatic release_rst(input int d);
    step();
    for (int e = 0; e < ND; e++) psel[e] = 1'b0;
    penable = 1'b0;
    #2;
    presetn[d] = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdat, input logic [3:0] strb,
                      input int abort_at, input int rst_at,
                      output logic [31:0] o_rd, output logic o_err,
                      output int o_lat, output logic [15:0] o_wp0);
    bit err;
    int idx;
    o_rd  = '0;
    o_err = 1'b0;
    o_lat = -1;
    err   = m_err(d, addr, wr);
    idx   = int'(addr >> 2);
    step();
    for (int e = 0; e < ND; e++) psel[e] = 1'b0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdat;
    pstrb   = strb;
    @(negedge PCLK);
    o_wp0 = wr_pulse[d];
    for (int k = 1; k <= waits[d] + 1; k++) begin
      step();
      penable = 1'b1;
      paddr   = $urandom;
      pwdata  = $urandom;
      pstrb   = 4'($urandom);
      if (k == abort_at) begin
        psel[d] = 1'b0;
        penable = 1'b0;
        @(negedge PCLK);
        return;
      end
      if (k == rst_at) begin
        #2;
        presetn[d] = 1'b0;
        model_reset(d);
        psel[d] = 1'b0;
        penable = 1'b0;
        @(negedge PCLK);
        return;
      end
      if (k == waits[d] + 1) begin
        exp_pready[d]  = 1'b1;
        exp_pslverr[d] = err;
        exp_prdata[d]  = (!wr && !err) ? m_read(d, addr) : 32'h0;
        if (wr && !err) begin
          pend_wr[d]   = 1'b1;
          pend_idx[d]  = idx;
          pend_dat[d]  = wdat;
          pend_strb[d] = strb;
        end
      end
      @(negedge PCLK);
      if (pready[d] && o_lat < 0) begin
        o_lat = k;
        o_rd  = prdata[d];
        o_err = pslverr[d];
      end
    end
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        er, w;
    logic [15:0] wp;
    logic [3:0]  st;
    int          lat, d, sel, ab;

    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    ro_m[0] = RO_A;
    ro_m[1] = RO_B;
    for (int e = 0; e < ND; e++) begin
      presetn[e] = 1'b1;
      psel[e]    = 1'b0;
      model_reset(e);
      for (int i = 0; i < NR; i++) begin
        rv[e][i] = (i == 3) ? 32'h12345678 : $urandom;
        ro_val[e][i*32 +: 32] = rv[e][i];
      end
    end
    #1;
    for (int e = 0; e < ND; e++) presetn[e] = 1'b0;
    #2;
    chk_en = 1'b1;
    idle(2);
    release_rst(0);
    release_rst(1);
    idle(1);

    // Strobed write then read, zero-wait slave
    xfer(0, 32'h08, 1'b1, 32'hDEADBEEF, 4'b0101, 0, 0, rd, er, lat, wp);
    chk("lat_a", 0, 0, lat, 1);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'hF, 0, 0, rd, er, lat, wp);
    chk("strb_rdata", 0, 2, rd, 32'h00AD00EF);
    chk("strb_err", 0, 2, {31'b0, er}, 32'h0);
    chk("wr_pulse_idx2", 0, 2, {16'b0, wp}, 32'h0000_0004);

    // Back-to-back write/read of 0x00
    xfer(0, 32'h00, 1'b1, 32'h11223344, 4'hF, 0, 0, rd, er, lat, wp);
    xfer(0, 32'h00, 1'b0, 32'h0, 4'h0, 0, 0, rd, er, lat, wp);
    chk("b2b_rdata", 0, 0, rd, 32'h11223344);

    // Error responses
    xfer(0, 32'h40, 1'b0, 32'h0, 4'hF, 0, 0, rd, er, lat, wp);
    chk("range_err", 0, 16, {31'b0, er}, 32'h1);
    chk("range_rdata", 0, 16, rd, 32'h0);
    xfer(0, 32'h06, 1'b1, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat, wp);
    chk("align_err", 0, 1, {31'b0, er}, 32'h1);
    xfer(0, 32'h0C, 1'b1, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat, wp);
    chk("ro_wr_err", 0, 3, {31'b0, er}, 32'h1);
    xfer(0, 32'h0C, 1'b0, 32'h0, 4'hF, 0, 0, rd, er, lat, wp);
    chk("ro_rdata", 0, 3, rd, 32'h12345678);
    chk("ro_rd_err", 0, 3, {31'b0, er}, 32'h0);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'hF, 0, 0, rd, er, lat, wp);
    chk("no_misaligned_wr", 0, 1, rd, 32'h0);

    // Three-wait slave: latency, abort, reset mid-WAIT
    xfer(1, 32'h04, 1'b0, 32'h0, 4'hF, 0, 0, rd, er, lat, wp);
    chk("lat_b", 1, 1, lat, 4);
    xfer(1, 32'h10, 1'b1, 32'hAAAA5555, 4'hF, 0, 0, rd, er, lat, wp);
    xfer(1, 32'h10, 1'b1, 32'h00000000, 4'hF, 2, 0, rd, er, lat, wp);
    chk("abort_no_ready", 1, 4, lat, -1);
    idle(3);
    xfer(1, 32'h10, 1'b0, 32'h0, 4'hF, 0, 0, rd, er, lat, wp);
    chk("abort_no_write", 1, 4, rd, 32'hAAAA5555);
    xfer(1, 32'h14, 1'b1, 32'hCAFEF00D, 4'hF, 0, 0, rd, er, lat, wp);
    xfer(1, 32'h14, 1'b1, 32'h00000001, 4'hF, 0, 2, rd, er, lat, wp);
    chk("rst_regq_zero", 1, 0, {31'b0, |reg_q[1]}, 32'h0);
    chk("rst_pready", 1, 0, {31'b0, pready[1]}, 32'h0);
    idle(2);
    release_rst(1);
    idle(1);
    xfer(1, 32'h14, 1'b0, 32'h0, 4'hF, 0, 0, rd, er, lat, wp);
    chk("rst_drop_write", 1, 5, rd, 32'h0);

    // Randomized traffic across both slaves
    for (int t = 0; t < 400; t++) begin
      d   = int'($urandom_range(ND - 1));
      sel = int'($urandom_range(9));
      if (sel == 0)      a = 32'h40 + ($urandom_range(15) << 2);
      else if (sel == 1) a = ($urandom_range(15) << 2) | $urandom_range(3, 1);
      else if (sel == 2) a = $urandom;
      else               a = $urandom_range(15) << 2;
      w  = 1'($urandom_range(1));
      wd = $urandom;
      st = 4'($urandom);
      ab = (d == 1 && $urandom_range(7) == 0) ? int'($urandom_range(3, 1)) : 0;
      xfer(d, a, w, wd, st, ab, 0, rd, er, lat, wp);
      if ($urandom_range(2) == 0) idle(int'($urandom_range(2, 1)));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
